// File: rtl/mem_pkg.sv
// Shared defaults and FSM encoding for the two-port memory arbiter.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
package mem_pkg;

  localparam int DW_DEF = 4;
  localparam int AW_DEF = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

endpackage

// File: rtl/reg_bank.sv
// Flip-flop word storage: one synchronous write port, one combinational read port.
// Latency: write lands on the clock edge; the read port reflects the stored word in the same cycle.
// Backpressure: none; every asserted write is accepted.
module reg_bank
  import mem_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          Re,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_dat,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_dat
);

  logic [DW-1:0] words [2**AW];

  // Storage words: cleared by reset, otherwise updated by the single write port.
  always_ff @(posedge clk or negedge Re) begin
    if (!Re) begin
      for (int i = 0; i < 2**AW; i++) begin
        words[i] <= '0;
      end
    end else if (wr_en) begin
      words[wr_addr] <= wr_dat;
    end
  end

  assign rd_dat = words[rd_addr];

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter granting two requesters one-at-a-time access to a shared word bank.
// Latency: request sampled at edge k -> grant in cycle k+1 -> write visible / rvalid in cycle k+2.
// Backpressure: requesters hold req until their grant; at most one transaction per two cycles.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          Re,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic [DW-1:0] rdata,
  output logic          rvalid
);

  state_t        state;
  state_t        next_state;
  logic          load;
  logic          win_nxt;
  logic          op_we;
  logic          op_id;
  logic [AW-1:0] op_addr;
  logic [DW-1:0] op_wdata;
  logic          last_win;
  logic          bank_wr_en;
  logic [DW-1:0] bank_rd_dat;

  // State register.
  always_ff @(posedge clk or negedge Re) begin
    if (!Re) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state, winner selection and grant decode.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    win_nxt    = 1'b0;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          load       = 1'b1;
          next_state = ACCESS;
          // Contested: whoever lost last time wins now; otherwise the lone requester.
          win_nxt    = (req0 && req1) ? ~last_win : req1;
        end
      end
      ACCESS: begin
        next_state = IDLE;
        gnt0       = ~op_id;
        gnt1       = op_id;
      end
      default: next_state = IDLE;
    endcase
  end

  // Capture the winner's operation so later input changes cannot disturb it.
  always_ff @(posedge clk or negedge Re) begin
    if (!Re) begin
      op_we    <= 1'b0;
      op_id    <= 1'b0;
      op_addr  <= '0;
      op_wdata <= '0;
    end else if (load) begin
      op_id    <= win_nxt;
      op_we    <= win_nxt ? we1    : we0;
      op_addr  <= win_nxt ? addr1  : addr0;
      op_wdata <= win_nxt ? wdata1 : wdata0;
    end
  end

  // Complete the transaction on the edge leaving ACCESS: read data, rvalid pulse, fairness pointer.
  always_ff @(posedge clk or negedge Re) begin
    if (!Re) begin
      rdata    <= '0;
      rvalid   <= 1'b0;
      last_win <= 1'b1;
    end else begin
      rvalid <= 1'b0;
      if (state == ACCESS) begin
        last_win <= op_id;
        if (!op_we) begin
          rdata  <= bank_rd_dat;
          rvalid <= 1'b1;
        end
      end
    end
  end

  assign bank_wr_en = (state == ACCESS) && op_we;

  reg_bank #(
    .DW(DW),
    .AW(AW)
  ) u_bank (
    .clk    (clk),
    .Re     (Re),
    .wr_en  (bank_wr_en),
    .wr_addr(op_addr),
    .wr_dat (op_wdata),
    .rd_addr(op_addr),
    .rd_dat (bank_rd_dat)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level model checked every cycle plus directed literal checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_arbiter;

  localparam int DW = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          Re  = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic          we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1;
  logic [DW-1:0] rdata;
  logic          rvalid;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk   (clk),
    .Re    (Re),
    .req0  (req0),
    .req1  (req1),
    .we0   (we0),
    .we1   (we1),
    .addr0 (addr0),
    .addr1 (addr1),
    .wdata0(wdata0),
    .wdata1(wdata1),
    .gnt0  (gnt0),
    .gnt1  (gnt1),
    .rdata (rdata),
    .rvalid(rvalid)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level model: a pending transaction is serviced one edge after it is accepted.
  logic [DW-1:0] m_mem [4];
  bit            m_busy;
  bit            m_win;
  bit            m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  bit            m_last;
  bit            e_gnt0, e_gnt1, e_rvalid;
  logic [DW-1:0] e_rdata;

  always @(posedge clk or negedge Re) begin
    if (!Re) begin
      for (int i = 0; i < 4; i++) m_mem[i] = '0;
      m_busy = 0; m_last = 1; m_win = 0; m_we = 0; m_addr = '0; m_wdata = '0;
      e_gnt0 = 0; e_gnt1 = 0; e_rvalid = 0; e_rdata = '0;
    end else begin
      e_gnt0 = 0; e_gnt1 = 0; e_rvalid = 0;
      if (m_busy) begin
        m_busy = 0;
        m_last = m_win;
        if (m_we) m_mem[m_addr] = m_wdata;
        else begin
          e_rdata  = m_mem[m_addr];
          e_rvalid = 1;
        end
      end else if (req0 || req1) begin
        m_win   = (req0 && req1) ? !m_last : bit'(req1);
        m_we    = m_win ? we1 : we0;
        m_addr  = m_win ? addr1 : addr0;
        m_wdata = m_win ? wdata1 : wdata0;
        m_busy  = 1;
        if (m_win) e_gnt1 = 1; else e_gnt0 = 1;
      end
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (!Re) begin
      check("rst_gnt0",   32'(gnt0),   32'd0);
      check("rst_gnt1",   32'(gnt1),   32'd0);
      check("rst_rvalid", 32'(rvalid), 32'd0);
      check("rst_rdata",  32'(rdata),  32'd0);
    end else begin
      check("gnt0",      32'(gnt0),        32'(e_gnt0));
      check("gnt1",      32'(gnt1),        32'(e_gnt1));
      check("rvalid",    32'(rvalid),      32'(e_rvalid));
      check("rdata",     32'(rdata),       32'(e_rdata));
      check("gnt_excl",  32'(gnt0 & gnt1), 32'd0);
    end
  end

  // One transaction from one requester; optionally change its wdata while in ACCESS.
  task automatic txn(input bit r, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                     input bit chg, input logic [DW-1:0] alt,
                     output logic rv, output logic [DW-1:0] rd, output int lat);
    if (r) begin req1 = 1; we1 = we; addr1 = a; wdata1 = wd; end
    else   begin req0 = 1; we0 = we; addr0 = a; wdata0 = wd; end
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if ((r ? gnt1 : gnt0) === 1'b1) begin
        lat = i;
        break;
      end
    end
    if (chg) begin
      if (r) wdata1 = alt; else wdata0 = alt;
    end
    @(posedge clk); #2;
    if (r) req1 = 0; else req0 = 0;
    @(negedge clk);
    rv = rvalid;
    rd = rdata;
  endtask

  logic          rv;
  logic [DW-1:0] rd;
  int            lat;
  int            order[$];
  int            exp_order[4] = '{0, 1, 0, 1};
  int            cnt;

  initial begin
    // Reset takes effect without any clock edge.
    #1 Re = 0;
    #1;
    check("rst0_gnt0",   32'(gnt0),   32'd0);
    check("rst0_gnt1",   32'(gnt1),   32'd0);
    check("rst0_rvalid", 32'(rvalid), 32'd0);
    check("rst0_rdata",  32'(rdata),  32'd0);
    @(negedge clk); @(posedge clk); #3 Re = 1;

    // Contention from reset: both write, grants must alternate starting with requester 0.
    we0 = 1; we1 = 1; addr0 = 0; addr1 = 1; wdata0 = 4'h1; wdata1 = 4'h2;
    req0 = 1; req1 = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (gnt0) order.push_back(0);
      if (gnt1) order.push_back(1);
    end
    req0 = 0; req1 = 0;
    check("cont_count", 32'(order.size() >= 4), 32'd1);
    if (order.size() >= 4)
      for (int i = 0; i < 4; i++) check("cont_order", 32'(order[i]), 32'(exp_order[i]));
    @(negedge clk); @(negedge clk);

    // Requester 0 raises req only while requester 1 is in ACCESS: it must never be granted.
    req1 = 1; we1 = 0; addr1 = 1;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (gnt1 === 1'b1) begin lat = i; break; end
    end
    check("drop_lat", 32'(lat), 32'd1);
    req0 = 1; we0 = 1; addr0 = 3; wdata0 = 4'hE;
    @(posedge clk); #2 req0 = 0; req1 = 0;
    @(negedge clk);
    check("drop_rvalid", 32'(rvalid), 32'd1);
    check("drop_rdata",  32'(rdata),  32'h2);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (gnt0) cnt++;
    end
    check("drop_no_gnt0", 32'(cnt), 32'd0);

    // Single write then read by requester 0.
    txn(0, 1, 2'd1, 4'hA, 0, 4'h0, rv, rd, lat);
    check("wr_lat", 32'(lat), 32'd1);
    check("wr_no_rvalid", 32'(rv), 32'd0);
    txn(0, 0, 2'd1, 4'h0, 0, 4'h0, rv, rd, lat);
    check("rd_lat", 32'(lat), 32'd1);
    check("rd_rvalid", 32'(rv), 32'd1);
    check("rd_data_A", 32'(rd), 32'hA);

    // Cross-requester write-then-read hazard, back to back.
    txn(1, 1, 2'd3, 4'h5, 0, 4'h0, rv, rd, lat);
    txn(0, 0, 2'd3, 4'h0, 0, 4'h0, rv, rd, lat);
    check("hazard_rvalid", 32'(rv), 32'd1);
    check("hazard_data", 32'(rd), 32'h5);

    // wdata changed during ACCESS must not affect the stored value.
    txn(1, 1, 2'd0, 4'h7, 1, 4'hF, rv, rd, lat);
    txn(0, 0, 2'd0, 4'h0, 0, 4'h0, rv, rd, lat);
    check("latch_data", 32'(rd), 32'h7);

    // Mid-run reset while a read result is on the outputs.
    txn(0, 1, 2'd2, 4'h6, 0, 4'h0, rv, rd, lat);
    req0 = 1; we0 = 0; addr0 = 2;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (gnt0 === 1'b1) begin lat = i; break; end
    end
    check("pre_rst_lat", 32'(lat), 32'd1);
    @(posedge clk); #1;
    check("pre_rst_rvalid", 32'(rvalid), 32'd1);
    check("pre_rst_rdata",  32'(rdata),  32'h6);
    #2 Re = 0; req0 = 0;
    #1;
    check("mid_rst_rvalid", 32'(rvalid), 32'd0);
    check("mid_rst_rdata",  32'(rdata),  32'd0);
    check("mid_rst_gnt",    32'({gnt0, gnt1}), 32'd0);
    @(posedge clk); #3 Re = 1;
    txn(0, 0, 2'd2, 4'h0, 0, 4'h0, rv, rd, lat);
    check("post_rst_rvalid", 32'(rv), 32'd1);
    check("post_rst_data",   32'(rd), 32'h0);

    // Reset pulse during ACCESS of a write aborts it.
    req0 = 1; we0 = 1; addr0 = 2; wdata0 = 4'h9;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (gnt0 === 1'b1) begin lat = i; break; end
    end
    check("abort_lat", 32'(lat), 32'd1);
    #2 Re = 0; req0 = 0;
    #2 Re = 1;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rvalid || gnt0 || gnt1) cnt++;
    end
    check("abort_quiet", 32'(cnt), 32'd0);
    txn(0, 0, 2'd2, 4'h0, 0, 4'h0, rv, rd, lat);
    check("abort_rvalid", 32'(rv), 32'd1);
    check("abort_data",   32'(rd), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
